// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: groups the instruction-memory read bus (req/ack) and
// the decode-side instruction handshake (valid/ready) of the fetch stage.
// Signal names are given from the fetch stage's point of view:
// o_* are driven by the fetch stage and i_* are driven by its environment.
interface instruction_fetch_if #(
  parameter int INSN_W = 32
);
  // Instruction-memory read channel
  logic              o_mem_req;
  logic [63:0]       o_mem_addr;
  logic              i_mem_ack;
  logic [INSN_W-1:0] i_mem_rdata;

  // Decode-side instruction channel
  logic              o_insn_valid;
  logic              i_insn_ready;
  logic [INSN_W-1:0] o_insn;
  logic [63:0]       o_insn_pc;
  logic              o_fetch_fault;

  modport master (
    output o_mem_req, o_mem_addr, o_insn_valid, o_insn, o_insn_pc, o_fetch_fault,
    input  i_mem_ack, i_mem_rdata, i_insn_ready
  );

  modport slave (
    input  o_mem_req, o_mem_addr, o_insn_valid, o_insn, o_insn_pc, o_fetch_fault,
    output i_mem_ack, i_mem_rdata, i_insn_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage behind the Program_Counter register.
// Issues one instruction-memory read per instruction, buffers the returned
// word for decode, and computes the program counter's next value every cycle
// (hold, advance by 4, or redirect), since the counter itself has no enable.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined, a fetch from
// an address with i_adress[1:0] != 0 is not sent to memory; instead a faulting
// slot (o_fetch_fault=1, o_insn=0) is presented to decode.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INSN_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [63:0]          i_adress,
  output logic [63:0]          o_counter,
  input  logic                 i_redirect,
  input  logic [63:0]          i_redirect_pc,
  instruction_fetch_if.master  bus
);

  typedef enum logic [0:0] {
    S_REQ = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t            r_state;
  logic [INSN_W-1:0] r_insn;
  logic [63:0]       r_insn_pc;

  state_t            w_state_nxt;
  logic [63:0]       w_counter;
  logic              w_mem_req;
  logic              w_capture;
  logic              w_capture_fault;
  logic              w_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = (i_adress[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // State register; reset returns to issuing a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, memory request, capture strobes and next-PC selection.
  always_comb begin
    w_state_nxt     = r_state;
    w_counter       = i_adress;
    w_mem_req       = 1'b0;
    w_capture       = 1'b0;
    w_capture_fault = 1'b0;
    if (i_rst) begin
      w_counter   = RESET_PC;
      w_state_nxt = S_REQ;
    end else if (i_redirect) begin
      // Redirect wins over ack/ready: any returning data or buffered word is
      // dropped. The request may still be visible; memory tolerates that.
      w_counter   = i_redirect_pc;
      w_state_nxt = S_REQ;
      w_mem_req   = (r_state == S_REQ) && !w_misaligned;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_misaligned) begin
            // Faulting slot: no memory access and no PC advance.
            w_capture_fault = 1'b1;
            w_state_nxt     = S_OUT;
          end else begin
            w_mem_req = 1'b1;
            if (bus.i_mem_ack) begin
              w_capture   = 1'b1;
              w_counter   = i_adress + 64'd4;
              w_state_nxt = S_OUT;
            end else begin
              w_counter = i_adress;
            end
          end
        end
        S_OUT: begin
          // PC already holds the advanced address; just wait for decode.
          if (bus.i_insn_ready) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_OUT;
          end
        end
        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  // Instruction buffer; only loaded on a good capture or a faulting slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_insn    <= {INSN_W{1'b0}};
      r_insn_pc <= 64'h0;
    end else if (w_capture) begin
      r_insn    <= bus.i_mem_rdata;
      r_insn_pc <= i_adress;
    end else if (w_capture_fault) begin
      r_insn    <= {INSN_W{1'b0}};
      r_insn_pc <= i_adress;
    end else begin
      r_insn    <= r_insn;
      r_insn_pc <= r_insn_pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  // Fault flag: set by a faulting slot, cleared by a good capture or redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fault <= 1'b0;
    end else if (i_redirect) begin
      r_fault <= 1'b0;
    end else if (w_capture) begin
      r_fault <= 1'b0;
    end else if (w_capture_fault) begin
      r_fault <= 1'b1;
    end else begin
      r_fault <= r_fault;
    end
  end

  assign bus.o_fetch_fault = r_fault;
`else
  assign bus.o_fetch_fault = 1'b0;
`endif

  assign o_counter        = w_counter;
  assign bus.o_mem_req    = w_mem_req;
  assign bus.o_mem_addr   = i_adress;
  assign bus.o_insn_valid = (r_state == S_OUT);
  assign bus.o_insn       = r_insn;
  assign bus.o_insn_pc    = r_insn_pc;

endmodule
